// File: rtl/pipeline_ifid_pkg.sv
// IF/ID shared definitions: instruction field positions, HLT opcode, bubble encoding, FSM states.
// No logic of its own; imported by every pipeline_ifid file.
// No backpressure; constants and a decode helper only.
package pipeline_ifid_pkg;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RS_MSB  = 7;
   localparam int RS_LSB  = 4;
   localparam int RT_MSB  = 3;
   localparam int RT_LSB  = 0;
   localparam int CNT_W   = 16;

   localparam logic [3:0]  OP_HLT    = 4'hF;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } ifid_state_t;

   function automatic logic is_hlt(input logic [15:0] instr);
      return instr[OPC_MSB:OPC_LSB] == OP_HLT;
   endfunction
endpackage

// File: rtl/pipeline_ifid_if.sv
// IF/ID bus: fetch-side inputs, ID/EX load info, latched slot outputs, perf counters.
// Pure wiring; no latency.
// The stall input is the backpressure; pc_write_en is returned to the fetch stage.
interface pipeline_ifid_if;
   import pipeline_ifid_pkg::*;

   logic [15:0]      instr_in;
   logic [15:0]      pc_plus2_in;
   logic             stall;
   logic             flush;
   logic             MemRead_IDEX;
   logic [3:0]       DstReg_IDEX;
   logic [15:0]      instr_out;
   logic [15:0]      pc_plus2_out;
   logic             nop_IFID;
   logic             halt_IFID;
   logic             pc_write_en;
   logic             nop_to_IDEX;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output instr_in, pc_plus2_in, stall, flush, MemRead_IDEX, DstReg_IDEX,
      input  instr_out, pc_plus2_out, nop_IFID, halt_IFID, pc_write_en, nop_to_IDEX,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  instr_in, pc_plus2_in, stall, flush, MemRead_IDEX, DstReg_IDEX,
      output instr_out, pc_plus2_out, nop_IFID, halt_IFID, pc_write_en, nop_to_IDEX,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/Bit16Reg.sv
// 16-bit register built from dff bits, synchronous active-low reset to zero.
// Latency: one cycle from d to q when wen is high.
// No backpressure; wen low simply holds.
module Bit16Reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        wen,
   input  logic [15:0] d,
   output logic [15:0] q
);
   for (genvar i = 0; i < 16; i++) begin : g_bit
      dff u_bit (
         .clk (clk),
         .rst (rst),
         .wen (wen),
         .d   (d[i]),
         .q   (q[i])
      );
   end
endmodule

// File: rtl/dff.sv
// Single-bit flop with write enable and synchronous active-low reset to RST_VAL.
// Latency: one cycle from d to q when wen is high.
// No backpressure; wen low simply holds.
module dff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic wen,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk) begin
      if (!rst)
         q <= RST_VAL;
      else if (wen)
         q <= d;
   end
endmodule

// File: rtl/hazard_detect.sv
// Load-use check: the load in ID/EX writes a register the latched IF/ID instruction reads.
// Latency: combinational.
// Produces backpressure only (hazard); consumes none.
module hazard_detect (
   input  logic       MemRead_IDEX,
   input  logic [3:0] DstReg_IDEX,
   input  logic [3:0] rs,
   input  logic [3:0] rt,
   input  logic       valid,
   output logic       hazard
);
   // r0 is hardwired, so a load "to r0" never creates a dependency.
   assign hazard = MemRead_IDEX && (DstReg_IDEX != 4'h0) && valid &&
                   ((DstReg_IDEX == rs) || (DstReg_IDEX == rt));
endmodule

// File: rtl/pipeline_ifid.sv
// IF/ID pipeline register with load-use hold, branch flush and HLT freeze; optional IFID_PERF_CNT_EN counters.
// Latency: one cycle from capture to outputs.
// Holds on stall or hazard; flush overrides hold; HLT freezes fetch until a flush.
module pipeline_ifid
   import pipeline_ifid_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   pipeline_ifid_if.slave bus
);
   ifid_state_t state;
   logic        hazard;
   logic        hold;
   logic        hlt_in;
   logic        capture;
   logic        reg_we;
   logic [15:0] instr_d;
   logic [15:0] pc_d;

   hazard_detect u_hazard (
      .MemRead_IDEX (bus.MemRead_IDEX),
      .DstReg_IDEX  (bus.DstReg_IDEX),
      .rs           (bus.instr_out[RS_MSB:RS_LSB]),
      .rt           (bus.instr_out[RT_MSB:RT_LSB]),
      .valid        (!bus.nop_IFID),
      .hazard       (hazard)
   );

   assign hold    = bus.stall | hazard;
   assign hlt_in  = is_hlt(bus.instr_in);
   assign capture = !bus.flush && !hold && (state == RUN);
   assign reg_we  = bus.flush | capture;
   assign instr_d = bus.flush ? NOP_INSTR : bus.instr_in;
   assign pc_d    = bus.flush ? 16'h0000 : bus.pc_plus2_in;

   Bit16Reg u_instr (
      .clk (clk), .rst (rst), .wen (reg_we), .d (instr_d), .q (bus.instr_out)
   );

   Bit16Reg u_pc (
      .clk (clk), .rst (rst), .wen (reg_we), .d (pc_d), .q (bus.pc_plus2_out)
   );

   // A flush loads a bubble; any capture loads a real instruction.
   dff #(.RST_VAL(1'b1)) u_nop (
      .clk (clk), .rst (rst), .wen (reg_we), .d (bus.flush), .q (bus.nop_IFID)
   );

   dff #(.RST_VAL(1'b0)) u_halt (
      .clk (clk), .rst (rst), .wen (reg_we), .d (!bus.flush && hlt_in), .q (bus.halt_IFID)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         state <= RUN;
      else if (bus.flush)
         state <= RUN;
      else if (capture && hlt_in)
         state <= HALTED;
   end

   assign bus.pc_write_en = bus.flush | (capture & !hlt_in);
   assign bus.nop_to_IDEX = hazard | bus.flush;

`ifdef IFID_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (bus.flush && flush_cnt_q != CNT_MAX)
            flush_cnt_q <= flush_cnt_q + 1'b1;
         if (hold && !bus.flush && stall_cnt_q != CNT_MAX)
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ifid.sv
// Directed bench for pipeline_ifid: per-cycle comparison against a behavioural model
// plus literal expectations for capture, load-use, flush, halt, reset and counter saturation.
module tb_pipeline_ifid;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pipeline_ifid_if bus ();

   pipeline_ifid dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model of the latched slot.
   logic [15:0] m_instr, m_pc;
   logic        m_nop, m_halt, m_halted;
   int          m_scnt, m_fcnt;
   bit          m_ok = 1'b0;

   function automatic logic m_hazard();
      return bus.MemRead_IDEX && bus.DstReg_IDEX != 4'h0 && !m_nop &&
             (bus.DstReg_IDEX == m_instr[7:4] || bus.DstReg_IDEX == m_instr[3:0]);
   endfunction

   function automatic logic m_pcwe();
      if (bus.flush) return 1'b1;
      if (bus.stall || m_hazard() || m_halted) return 1'b0;
      return bus.instr_in[15:12] != 4'hF;
   endfunction

   function automatic logic [15:0] m_cnt(input int v);
`ifdef IFID_PERF_CNT_EN
      return (v > 65535) ? 16'hFFFF : v[15:0];
`else
      return (v < 0) ? 16'h0001 : 16'h0000;
`endif
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         m_instr = 16'h0; m_pc = 16'h0; m_nop = 1'b1; m_halt = 1'b0;
         m_halted = 1'b0; m_scnt = 0; m_fcnt = 0; m_ok = 1'b1;
      end else if (m_ok) begin
         if (bus.flush) begin
            m_fcnt++;
            m_instr = 16'h0; m_pc = 16'h0; m_nop = 1'b1; m_halt = 1'b0; m_halted = 1'b0;
         end else if (bus.stall || m_hazard()) begin
            m_scnt++;
         end else if (!m_halted) begin
            m_instr = bus.instr_in; m_pc = bus.pc_plus2_in; m_nop = 1'b0;
            m_halt = (bus.instr_in[15:12] == 4'hF);
            m_halted = m_halt;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_instr_out", bus.instr_out, m_instr);
         chk("m_pc_plus2_out", bus.pc_plus2_out, m_pc);
         chk("m_nop_IFID", {15'd0, bus.nop_IFID}, {15'd0, m_nop});
         chk("m_halt_IFID", {15'd0, bus.halt_IFID}, {15'd0, m_halt});
         chk("m_pc_write_en", {15'd0, bus.pc_write_en}, {15'd0, m_pcwe()});
         chk("m_nop_to_IDEX", {15'd0, bus.nop_to_IDEX}, {15'd0, m_hazard() || bus.flush});
         chk("m_stall_cnt", bus.stall_cnt, m_cnt(m_scnt));
         chk("m_flush_cnt", bus.flush_cnt, m_cnt(m_fcnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_instr"}, bus.instr_out, 16'h0000);
      chk({tag, "_pc"}, bus.pc_plus2_out, 16'h0000);
      chk({tag, "_nop"}, {15'd0, bus.nop_IFID}, 16'h0001);
      chk({tag, "_halt"}, {15'd0, bus.halt_IFID}, 16'h0000);
      chk({tag, "_scnt"}, bus.stall_cnt, 16'h0000);
      chk({tag, "_fcnt"}, bus.flush_cnt, 16'h0000);
   endtask

   initial begin
      bus.instr_in = 16'h0; bus.pc_plus2_in = 16'h0; bus.stall = 1'b0; bus.flush = 1'b0;
      bus.MemRead_IDEX = 1'b0; bus.DstReg_IDEX = 4'h0;
      rst = 1'b0;
      tick(); tick();
      chk_reset_state("rst");

      // Plain capture
      rst = 1'b1; bus.instr_in = 16'h1234; bus.pc_plus2_in = 16'h0010;
      tick();
      chk("cap_instr", bus.instr_out, 16'h1234);
      chk("cap_pc", bus.pc_plus2_out, 16'h0010);
      chk("cap_nop", {15'd0, bus.nop_IFID}, 16'h0000);

      // Load-use on rs, then rt, then a load to r0
      bus.instr_in = 16'h2153; bus.pc_plus2_in = 16'h0012;
      tick();
      bus.MemRead_IDEX = 1'b1; bus.DstReg_IDEX = 4'h5;
      bus.instr_in = 16'h4444; bus.pc_plus2_in = 16'h0014;
      #1;
      chk("lu_nop_to_IDEX", {15'd0, bus.nop_to_IDEX}, 16'h0001);
      chk("lu_pcwe", {15'd0, bus.pc_write_en}, 16'h0000);
      tick();
      chk("lu_held_instr", bus.instr_out, 16'h2153);
      chk("lu_held_pc", bus.pc_plus2_out, 16'h0012);
      bus.DstReg_IDEX = 4'h3;
      #1;
      chk("lu_rt_nop_to_IDEX", {15'd0, bus.nop_to_IDEX}, 16'h0001);
      tick();
      bus.DstReg_IDEX = 4'h0;
      #1;
      chk("r0_nop_to_IDEX", {15'd0, bus.nop_to_IDEX}, 16'h0000);
      chk("r0_pcwe", {15'd0, bus.pc_write_en}, 16'h0001);
      tick();
      chk("r0_cap_instr", bus.instr_out, 16'h4444);
      bus.MemRead_IDEX = 1'b0;

      // Flush while stalled
      bus.stall = 1'b1; bus.flush = 1'b1;
      #1;
      chk("fl_pcwe", {15'd0, bus.pc_write_en}, 16'h0001);
      tick();
      chk("fl_nop", {15'd0, bus.nop_IFID}, 16'h0001);
      chk("fl_instr", bus.instr_out, 16'h0000);
`ifdef IFID_PERF_CNT_EN
      chk("fl_fcnt", bus.flush_cnt, 16'h0001);
      chk("fl_scnt", bus.stall_cnt, 16'h0002);
`endif
      bus.flush = 1'b0;

      // HLT arriving under stall is not taken
      bus.instr_in = 16'hF000; bus.pc_plus2_in = 16'h0020;
      tick();
      chk("hs_halt", {15'd0, bus.halt_IFID}, 16'h0000);
      chk("hs_nop", {15'd0, bus.nop_IFID}, 16'h0001);

      // HLT captured, fetch frozen, then released by flush
      bus.stall = 1'b0;
      tick();
      chk("h_halt", {15'd0, bus.halt_IFID}, 16'h0001);
      chk("h_instr", bus.instr_out, 16'hF000);
      bus.instr_in = 16'h1111; bus.pc_plus2_in = 16'h0022;
      #1;
      chk("h_pcwe", {15'd0, bus.pc_write_en}, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("h_frozen_instr", bus.instr_out, 16'hF000);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("hf_nop", {15'd0, bus.nop_IFID}, 16'h0001);
      chk("hf_halt", {15'd0, bus.halt_IFID}, 16'h0000);
      bus.instr_in = 16'h1234; bus.pc_plus2_in = 16'h0024;
      tick();
      chk("hf_cap_instr", bus.instr_out, 16'h1234);

      // Reset while halted
      bus.instr_in = 16'hF000;
      tick();
      bus.instr_in = 16'h1111;
      tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk_reset_state("rh");
      bus.instr_in = 16'h1234; bus.pc_plus2_in = 16'h0030;
      tick();
      chk("rh_cap_instr", bus.instr_out, 16'h1234);
      chk("rh_cap_pc", bus.pc_plus2_out, 16'h0030);
      chk("rh_cap_nop", {15'd0, bus.nop_IFID}, 16'h0000);

      // Reset while stalled
      bus.stall = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1; bus.stall = 1'b0; bus.instr_in = 16'h5678;
      tick();
      chk("rs_cap_instr", bus.instr_out, 16'h5678);

      // Stall counter saturation
      rst = 1'b0;
      tick();
      rst = 1'b1; bus.stall = 1'b1;
`ifdef IFID_PERF_CNT_EN
      repeat (65534) tick();
      chk("sat_pre", bus.stall_cnt, 16'hFFFE);
      repeat (3) tick();
      chk("sat_cnt", bus.stall_cnt, 16'hFFFF);
`else
      repeat (3) tick();
      chk("off_scnt", bus.stall_cnt, 16'h0000);
`endif
      bus.stall = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
